// File: rtl/wired_cdb_arbiter.sv
// wired_cdb_arbiter: banked two-port CDB arbiter with starvation promotion.
// Each ROB bank (wid[0]) owns one broadcast port; results are registered one cycle later.
package wired_cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [5:0]  wid;
        logic [31:0] data;
    } pipeline_cdb_t;
endpackage

module wired_cdb_arbiter
    import wired_cdb_pkg::*;
#(
    parameter int SRC_CNT      = 4,
    parameter int STARVE_LIMIT = 7,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    input  pipeline_cdb_t [SRC_CNT-1:0] src_cdb_i,
    input  logic [SRC_CNT-1:0]          src_valid_i,
    output logic [SRC_CNT-1:0]          src_ready_o,
    output pipeline_cdb_t [1:0]         cdb_o
);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]          wait_q [SRC_CNT];
    logic [CNT_W-1:0]          wait_d [SRC_CNT];
    logic [1:0][SRC_CNT-1:0]   cand, starv, pick;
    pipeline_cdb_t [1:0]       cdb_q, cdb_d;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar i = 0; i < SRC_CNT; i++) begin : g_src
            assign cand[b][i]  = src_valid_i[i] && (src_cdb_i[i].wid[0] == 1'(b)) && !flush_i;
            assign starv[b][i] = cand[b][i] && (wait_q[i] >= LIMIT);
        end
        // x & -x isolates the lowest set bit, i.e. the highest-priority requester
        assign pick[b] = |starv[b] ? starv[b] & -starv[b] : cand[b] & -cand[b];
    end

    assign src_ready_o = (pick[0] | pick[1]) & {SRC_CNT{rst_n}};

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            cdb_d[b] = '0;
            for (int i = 0; i < SRC_CNT; i++)
                if (pick[b][i]) cdb_d[b] = src_cdb_i[i];
            cdb_d[b].valid = |pick[b];
        end
        for (int i = 0; i < SRC_CNT; i++)
            wait_d[i] = (flush_i || !src_valid_i[i] || pick[0][i] || pick[1][i]) ? '0 :
                        (wait_q[i] == LIMIT) ? LIMIT : wait_q[i] + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_q <= '0;
            for (int i = 0; i < SRC_CNT; i++) wait_q[i] <= '0;
        end else begin
            cdb_q <= cdb_d;
            for (int i = 0; i < SRC_CNT; i++) wait_q[i] <= wait_d[i];
        end
    end

    assign cdb_o = cdb_q;
endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// tb_wired_cdb_arbiter: vector table, directed corner sequences and random traffic
// compared against a priority/starvation reference model.
module tb_wired_cdb_arbiter;
    import wired_cdb_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0, flush_i = 1'b0;
    pipeline_cdb_t [3:0] src_cdb_i = '0;
    logic [3:0] src_valid_i = '0, src_ready_o;
    pipeline_cdb_t [1:0] cdb_o;

    always #5 clk = ~clk;

    wired_cdb_arbiter dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .src_cdb_i(src_cdb_i),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .cdb_o(cdb_o)
    );

    int total = 0, passed = 0;
    int wq[4];
    pipeline_cdb_t mcdb[2];
    logic [3:0] last_rdy;

    typedef struct {
        logic [3:0]      v;
        logic [3:0][5:0] w;
        logic            f;
        logic [3:0]      rdy;
        logic [1:0]      cv;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(logic [3:0] v, logic [3:0][5:0] w, logic f);
        for (int i = 0; i < 4; i++) begin
            src_cdb_i[i].valid = ~v[i];
            src_cdb_i[i].wid   = w[i];
            src_cdb_i[i].data  = 32'hD000 + 32'(i);
        end
        src_valid_i = v;
        flush_i     = f;
    endtask

    task automatic check_state();
        for (int b = 0; b < 2; b++) begin
            chk("cdb_valid", 64'(cdb_o[b].valid), 64'(mcdb[b].valid));
            if (mcdb[b].valid)
                chk("cdb_payload", 64'({cdb_o[b].wid, cdb_o[b].data}), 64'({mcdb[b].wid, mcdb[b].data}));
        end
        for (int i = 0; i < 4; i++) chk("wait_q", 64'(dut.wait_q[i]), 64'(wq[i]));
    endtask

    // Reference: starved sources (wait >= 7) beat everyone, then lowest index, per bank.
    task automatic cycle();
        logic [3:0] rdy;
        pipeline_cdb_t nc[2];
        int best;
        rdy = '0;
        for (int b = 0; b < 2; b++) begin
            best = -1;
            for (int pass = 0; pass < 2; pass++)
                for (int i = 0; i < 4; i++)
                    if (best < 0 && src_valid_i[i] && !flush_i && (src_cdb_i[i].wid[0] == (b == 1))
                        && (pass == 1 || wq[i] >= 7)) best = i;
            nc[b] = '0;
            if (best >= 0) begin
                rdy[best]   = 1'b1;
                nc[b]       = src_cdb_i[best];
                nc[b].valid = 1'b1;
            end
        end
        @(negedge clk);
        chk("ready", 64'(src_ready_o), 64'(rdy));
        last_rdy = src_ready_o;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++)
            wq[i] = (flush_i || !src_valid_i[i] || rdy[i]) ? 0 : (wq[i] < 7 ? wq[i] + 1 : 7);
        mcdb[0] = nc[0];
        mcdb[1] = nc[1];
        check_state();
    endtask

    initial begin
        tbl[0] = '{4'b0101, {6'd0, 6'd7, 6'd0, 6'd4}, 1'b0, 4'b0101, 2'b11};
        tbl[1] = '{4'b1010, {6'd6, 6'd0, 6'd2, 6'd0}, 1'b0, 4'b0010, 2'b01};
        tbl[2] = '{4'b1111, {6'd6, 6'd4, 6'd2, 6'd0}, 1'b0, 4'b0001, 2'b01};
        tbl[3] = '{4'b1111, {6'd7, 6'd5, 6'd3, 6'd1}, 1'b0, 4'b0001, 2'b10};
        tbl[4] = '{4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}, 1'b0, 4'b0011, 2'b11};
        tbl[5] = '{4'b1111, {6'd3, 6'd2, 6'd1, 6'd0}, 1'b1, 4'b0000, 2'b00};
        tbl[6] = '{4'b1000, {6'd9, 6'd0, 6'd0, 6'd0}, 1'b0, 4'b1000, 2'b10};
        tbl[7] = '{4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}, 1'b0, 4'b0000, 2'b00};
        for (int i = 0; i < 4; i++) wq[i] = 0;
        mcdb[0] = '0;
        mcdb[1] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 64'(src_ready_o), 64'(0));
        check_state();
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].w, tbl[k].f);
            cycle();
            chk("tbl_rdy", 64'(last_rdy), 64'(tbl[k].rdy));
            chk("tbl_cdbv", 64'({cdb_o[1].valid, cdb_o[0].valid}), 64'(tbl[k].cv));
            drive(4'b0000, '0, 1'b0);
            cycle();
        end

        // Same-bank priority, loser follows once the winner drops
        drive(4'b1010, {6'd6, 6'd0, 6'd2, 6'd0}, 1'b0);
        cycle();
        chk("prio_first", 64'(last_rdy), 64'(4'b0010));
        drive(4'b1000, {6'd6, 6'd0, 6'd2, 6'd0}, 1'b0);
        cycle();
        chk("prio_second", 64'(last_rdy), 64'(4'b1000));
        chk("prio_wid", 64'(cdb_o[0].wid), 64'(6));

        // Starvation promotion of src3 against a continuously valid src0
        drive(4'b1001, {6'd8, 6'd0, 6'd0, 6'd0}, 1'b0);
        for (int c = 1; c <= 9; c++) begin
            cycle();
            chk("starve_rdy", 64'(last_rdy), 64'(c == 8 ? 4'b1000 : 4'b0001));
            if (c == 7) chk("starve_wait7", 64'(dut.wait_q[3]), 64'(7));
            if (c == 8) chk("starve_wait0", 64'(dut.wait_q[3]), 64'(0));
        end

        // Flush after building up wait counts
        drive(4'b1111, {6'd6, 6'd4, 6'd2, 6'd0}, 1'b0);
        repeat (3) cycle();
        drive(4'b1111, {6'd6, 6'd4, 6'd2, 6'd0}, 1'b1);
        cycle();
        chk("flush_rdy", 64'(last_rdy), 64'(0));

        drive(4'b0000, '0, 1'b0);
        repeat (10) cycle();

        // Asynchronous reset in the middle of a broadcast
        drive(4'b0011, {6'd0, 6'd0, 6'd2, 6'd0}, 1'b0);
        repeat (2) cycle();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_cdbv", 64'({cdb_o[1].valid, cdb_o[0].valid}), 64'(0));
        chk("rst_wait1", 64'(dut.wait_q[1]), 64'(0));
        chk("rst_ready", 64'(src_ready_o), 64'(0));
        for (int i = 0; i < 4; i++) wq[i] = 0;
        mcdb[0] = '0;
        mcdb[1] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_release_cdbv", 64'({cdb_o[1].valid, cdb_o[0].valid}), 64'(0));
        cycle();
        chk("rst_first_grant", 64'(last_rdy), 64'(4'b0001));

        // Random traffic; producers hold their payload until accepted
        drive(4'b0000, '0, 1'b0);
        last_rdy = '0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++)
                if (!src_valid_i[i] || last_rdy[i]) begin
                    src_valid_i[i]     = ($urandom_range(0, 3) != 0);
                    src_cdb_i[i].valid = 1'($urandom);
                    src_cdb_i[i].wid   = 6'($urandom);
                    src_cdb_i[i].data  = $urandom;
                end
            flush_i = ($urandom_range(0, 15) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
